// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges a 1-entry ALU holding register and an LD_DEPTH load FIFO onto the
// register-file write port. Optional forwarding ports are enabled with `define WB_FORWARD_EN.
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

module writeback_arbiter #(
  parameter int DATA_W   = `DATA_WIDTH,
  parameter int ADDR_W   = `REGADDR_WIDTH,
  parameter int LD_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_rd,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDR_W-1:0]          ld_rd,
  input  logic [DATA_W-1:0]          ld_data,
  output logic                       rf_writeEnable,
  output logic [ADDR_W-1:0]          rf_writeSelect,
  output logic [DATA_W-1:0]          rf_dataIn,
  output logic [31:0]                pend_mask,
  output logic [$clog2(LD_DEPTH):0]  ld_count
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]          fwdA_select,
  input  logic [ADDR_W-1:0]          fwdB_select,
  output logic                       fwdA_hit,
  output logic [DATA_W-1:0]          fwdA_data,
  output logic                       fwdB_hit,
  output logic [DATA_W-1:0]          fwdB_data
`endif
);

  localparam int PTR_W = $clog2(LD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LD_DEPTH);

  logic              alu_hold_v;
  logic [ADDR_W-1:0] alu_hold_rd;
  logic [DATA_W-1:0] alu_hold_data;

  logic [ADDR_W-1:0] ld_rd_mem   [LD_DEPTH];
  logic [DATA_W-1:0] ld_data_mem [LD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rr;

  logic ld_head_v;
  logic grant_alu;
  logic grant_ld;
  logic alu_push;
  logic ld_push;

  // Grant depends only on registered state, so ready never loops back through valid.
  always_comb begin
    ld_head_v = (ld_count != '0);
    grant_alu = alu_hold_v && (!ld_head_v || !rr);
    grant_ld  = ld_head_v && (!alu_hold_v || rr);
  end

  assign alu_ready = !alu_hold_v || grant_alu;
  assign ld_ready  = (ld_count < FULL_CNT) || grant_ld;
  // rd==0 completes the handshake but is never stored.
  assign alu_push  = alu_valid && alu_ready && (alu_rd != '0);
  assign ld_push   = ld_valid && ld_ready && (ld_rd != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_hold_v    <= 1'b0;
      alu_hold_rd   <= '0;
      alu_hold_data <= '0;
    end else if (alu_push) begin
      alu_hold_v    <= 1'b1;
      alu_hold_rd   <= alu_rd;
      alu_hold_data <= alu_data;
    end else if (grant_alu) begin
      alu_hold_v    <= 1'b0;
    end
  end

  // NOTE: FIFO storage has no reset; ld_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (ld_push) begin
      ld_rd_mem[wr_ptr]   <= ld_rd;
      ld_data_mem[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ld_count <= '0;
    end else begin
      if (ld_push)  wr_ptr <= wr_ptr + 1'b1;
      if (grant_ld) rd_ptr <= rd_ptr + 1'b1;
      case ({ld_push, grant_ld})
        2'b10:   ld_count <= ld_count + 1'b1;
        2'b01:   ld_count <= ld_count - 1'b1;
        default: ld_count <= ld_count;
      endcase
    end
  end

  // Round-robin pointer moves to the loser only when both sources competed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= 1'b0;
    end else if (grant_alu && ld_head_v) begin
      rr <= 1'b1;
    end else if (grant_ld && alu_hold_v) begin
      rr <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_writeEnable <= 1'b0;
      rf_writeSelect <= '0;
      rf_dataIn      <= '0;
    end else if (grant_alu) begin
      rf_writeEnable <= 1'b1;
      rf_writeSelect <= alu_hold_rd;
      rf_dataIn      <= alu_hold_data;
    end else if (grant_ld) begin
      rf_writeEnable <= 1'b1;
      rf_writeSelect <= ld_rd_mem[rd_ptr];
      rf_dataIn      <= ld_data_mem[rd_ptr];
    end else begin
      rf_writeEnable <= 1'b0;
    end
  end

  // NOTE: the default assignment first keeps this combinational block free of latches.
  always_comb begin
    pend_mask = '0;
    if (alu_hold_v) pend_mask[alu_hold_rd] = 1'b1;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (CNT_W'(i) < ld_count) pend_mask[ld_rd_mem[rd_ptr + PTR_W'(i)]] = 1'b1;
    end
    if (rf_writeEnable) pend_mask[rf_writeSelect] = 1'b1;
    pend_mask[0] = 1'b0;
  end

`ifdef WB_FORWARD_EN
  // Covers the write sitting on rf_* that the register file read ports cannot see yet.
  assign fwdA_hit  = rf_writeEnable && (rf_writeSelect == fwdA_select) && (fwdA_select != '0);
  assign fwdA_data = fwdA_hit ? rf_dataIn : '0;
  assign fwdB_hit  = rf_writeEnable && (rf_writeSelect == fwdB_select) && (fwdB_select != '0);
  assign fwdB_data = fwdB_hit ? rf_dataIn : '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based transaction model.
`timescale 1ns/1ps

module tb_writeback_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int LD_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              alu_valid = 1'b0;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              rf_writeEnable;
  logic [ADDR_W-1:0] rf_writeSelect;
  logic [DATA_W-1:0] rf_dataIn;
  logic [31:0]       pend_mask;
  logic [$clog2(LD_DEPTH):0] ld_count;
`ifdef WB_FORWARD_EN
  logic [ADDR_W-1:0] fwdA_select = '0;
  logic [ADDR_W-1:0] fwdB_select = '0;
  logic              fwdA_hit, fwdB_hit;
  logic [DATA_W-1:0] fwdA_data, fwdB_data;
`endif

  writeback_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rf_writeEnable(rf_writeEnable), .rf_writeSelect(rf_writeSelect), .rf_dataIn(rf_dataIn),
    .pend_mask(pend_mask), .ld_count(ld_count)
`ifdef WB_FORWARD_EN
    , .fwdA_select(fwdA_select), .fwdB_select(fwdB_select),
    .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data), .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: pending results as queues, plus the registered write port.
  ent_t alu_q[$];
  ent_t ld_q[$];
  logic m_rr;
  logic m_we;
  ent_t m_out;
  int   m_g;          // 0 none, 1 ALU, 2 load
  logic m_alu_rdy, m_ld_rdy;
  logic s_alu_rdy, s_ld_rdy;

  task automatic model_clear();
    alu_q.delete();
    ld_q.delete();
    m_rr  = 1'b0;
    m_we  = 1'b0;
    m_out = '0;
  endtask

  function automatic logic [31:0] m_pend();
    logic [31:0] m = '0;
    foreach (alu_q[i]) m[alu_q[i].rd] = 1'b1;
    foreach (ld_q[i])  m[ld_q[i].rd]  = 1'b1;
    if (m_we) m[m_out.rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // Called at a negedge: drives one cycle of inputs, advances the model over the posedge,
  // and returns at the following negedge.
  task automatic step(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adat,
                      input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ldat);
    bit   a, l, contested;
    ent_t e;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldat;
    a = (alu_q.size() > 0);
    l = (ld_q.size() > 0);
    contested = a && l;
    if (contested)  m_g = m_rr ? 2 : 1;
    else if (a)     m_g = 1;
    else if (l)     m_g = 2;
    else            m_g = 0;
    m_alu_rdy = (alu_q.size() == 0) || (m_g == 1);
    m_ld_rdy  = (ld_q.size() < LD_DEPTH) || (m_g == 2);
    #1;
    s_alu_rdy = alu_ready;
    s_ld_rdy  = ld_ready;
    @(posedge clk);
    if (m_g == 1)      begin m_out = alu_q.pop_front(); m_we = 1'b1; end
    else if (m_g == 2) begin m_out = ld_q.pop_front();  m_we = 1'b1; end
    else                m_we = 1'b0;
    if (contested) m_rr = (m_g == 1);
    if (av && m_alu_rdy && ard != '0) begin e.rd = ard; e.data = adat; alu_q.push_back(e); end
    if (lv && m_ld_rdy && lrd != '0)  begin e.rd = lrd; e.data = ldat; ld_q.push_back(e);  end
    @(negedge clk);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    repeat (2) @(negedge clk);
    total++; if (rf_writeEnable !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", rf_writeEnable); end
    total++; if (ld_count !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", ld_count); end
    total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL reset_pend: got %h want 0", pend_mask); end
    total++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b%b want 11", alu_ready, ld_ready); end
    total++; if (rf_writeSelect !== '0 || rf_dataIn !== '0) begin bad++; $display("FAIL reset_rf: got %0d/%h want 0/0", rf_writeSelect, rf_dataIn); end
    reset = 1'b0;
    // Contended traffic builds up three queued loads, then reset lands between edges.
    for (int i = 0; i < 4; i++) step(1'b1, 5'd3, 32'h100 + i, 1'b1, 5'd20 + 5'(i), 32'h200 + i);
    total++; if (ld_count !== 3) begin bad++; $display("FAIL midreset_pre_cnt: got %0d want 3", ld_count); end
    #3 reset = 1'b1;
    #1;
    total++; if (ld_count !== '0) begin bad++; $display("FAIL midreset_cnt: got %0d want 0", ld_count); end
    total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL midreset_pend: got %h want 0", pend_mask); end
    total++; if (rf_writeEnable !== 1'b0) begin bad++; $display("FAIL midreset_we: got %b want 0", rf_writeEnable); end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_alu();
    do_reset();
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    total++; if (pend_mask !== 32'h20) begin bad++; $display("FAIL alu_pend_e: got %h want 20", pend_mask); end
    total++; if (rf_writeEnable !== 1'b0) begin bad++; $display("FAIL alu_we_e: got %b want 0", rf_writeEnable); end
    step(1'b0, '0, '0, 1'b0, '0, '0);
    total++; if ({rf_writeEnable, rf_writeSelect, rf_dataIn} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      bad++; $display("FAIL alu_commit: got %b/%0d/%h want 1/5/deadbeef", rf_writeEnable, rf_writeSelect, rf_dataIn); end
    total++; if (pend_mask !== 32'h20) begin bad++; $display("FAIL alu_pend_e1: got %h want 20", pend_mask); end
    step(1'b0, '0, '0, 1'b0, '0, '0);
    total++; if (rf_writeEnable !== 1'b0 || pend_mask !== 32'h0) begin
      bad++; $display("FAIL alu_done: got we=%b pend=%h want 0/0", rf_writeEnable, pend_mask); end
    total++; if (rf_writeSelect !== 5'd5 || rf_dataIn !== 32'hDEADBEEF) begin
      bad++; $display("FAIL alu_hold_rf: got %0d/%h want 5/deadbeef", rf_writeSelect, rf_dataIn); end
  endtask

  task automatic test_contention();
    int a_cnt = 0, l_cnt = 0, next_a = 0, next_l = 0, commits = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 5'd1, 32'(a_cnt), 1'b1, 5'd2, 32'(1000 + l_cnt));
      if (m_alu_rdy) a_cnt++;
      if (m_ld_rdy)  l_cnt++;
      if (i >= 1) begin
        total++; if (rf_writeEnable !== 1'b1) begin bad++; $display("FAIL cont_we[%0d]: got %b want 1", i, rf_writeEnable); end
        if (rf_writeEnable === 1'b1) begin
          total++;
          if (rf_writeSelect !== ((commits % 2 == 0) ? 5'd1 : 5'd2)) begin
            bad++; $display("FAIL cont_order[%0d]: got rd=%0d want %0d", commits, rf_writeSelect, (commits % 2 == 0) ? 1 : 2);
          end
          total++;
          if (rf_writeSelect == 5'd1) begin
            if (rf_dataIn !== 32'(next_a)) begin bad++; $display("FAIL cont_alu_data: got %0d want %0d", rf_dataIn, next_a); end
            next_a++;
          end else begin
            if (rf_dataIn !== 32'(1000 + next_l)) begin bad++; $display("FAIL cont_ld_data: got %0d want %0d", rf_dataIn, 1000 + next_l); end
            next_l++;
          end
          commits++;
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    int k = 0, j = 0, max_cnt = 0;
    bit full_pop_seen = 0, lv;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      lv = (k < 10);
      if (lv && ld_q.size() == LD_DEPTH && m_rr) full_pop_seen = 1;
      step(lv, 5'd1, 32'hA000 + c, lv, 5'd8 + 5'(k % 4), 32'(200 + k));
      if (ld_q.size() == LD_DEPTH || m_g == 2) begin
        // Only meaningful on full-FIFO cycles; readiness must then equal the load grant.
      end
      if (int'(ld_count) > max_cnt) max_cnt = int'(ld_count);
      if (lv && m_ld_rdy) k++;
      if (rf_writeEnable === 1'b1 && rf_writeSelect >= 5'd8 && rf_writeSelect <= 5'd11) begin
        total++;
        if (rf_writeSelect !== 5'd8 + 5'(j % 4) || rf_dataIn !== 32'(200 + j)) begin
          bad++; $display("FAIL fifo_order[%0d]: got %0d/%0d want %0d/%0d", j, rf_writeSelect, rf_dataIn, 8 + j % 4, 200 + j);
        end
        j++;
      end
    end
    total++; if (max_cnt !== 4) begin bad++; $display("FAIL fifo_max_cnt: got %0d want 4", max_cnt); end
    total++; if (j !== 10) begin bad++; $display("FAIL fifo_loads_out: got %0d want 10", j); end
    total++; if (full_pop_seen !== 1'b1) begin bad++; $display("FAIL fifo_full_pop: got %b want 1", full_pop_seen); end
    total++; if (ld_count !== '0) begin bad++; $display("FAIL fifo_drained: got %0d want 0", ld_count); end
  endtask

  task automatic test_full_ready();
    // Saturate both sources and check ld_ready on every full-FIFO cycle.
    int full_cycles = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 5'd1, 32'(c), 1'b1, 5'd9, 32'(c));
      if (ld_q.size() == LD_DEPTH || (m_ld_rdy != 1'b1)) full_cycles++;
      total++;
      if (s_ld_rdy !== m_ld_rdy) begin bad++; $display("FAIL full_ld_ready[%0d]: got %b want %b", c, s_ld_rdy, m_ld_rdy); end
    end
    total++; if (full_cycles == 0) begin bad++; $display("FAIL full_ld_stall: got 0 stalled cycles want >0"); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    step(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0);
    total++; if (s_alu_ready_chk() !== 1'b1) begin bad++; $display("FAIL rd0_ready: got %b want 1", s_alu_rdy); end
    total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL rd0_pend0: got %h want 0", pend_mask); end
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'h5678);
    total++; if (rf_writeEnable !== 1'b0 || pend_mask !== 32'h0) begin
      bad++; $display("FAIL rd0_no_write1: got we=%b pend=%h want 0/0", rf_writeEnable, pend_mask); end
    total++; if (s_ld_rdy !== 1'b1) begin bad++; $display("FAIL rd0_ld_ready: got %b want 1", s_ld_rdy); end
    step(1'b0, '0, '0, 1'b0, '0, '0);
    total++; if (rf_writeEnable !== 1'b0 || pend_mask !== 32'h0 || ld_count !== '0) begin
      bad++; $display("FAIL rd0_no_write2: got we=%b pend=%h cnt=%0d want 0/0/0", rf_writeEnable, pend_mask, ld_count); end
  endtask

  function automatic logic s_alu_ready_chk();
    return s_alu_rdy;
  endfunction

  task automatic test_random();
    logic av, lv;
    logic [ADDR_W-1:0] ard, lrd;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      av  = ($urandom_range(0, 9) < 7);
      lv  = ($urandom_range(0, 9) < 6);
      ard = 5'($urandom_range(0, 15));
      lrd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
      step(av, ard, $urandom, lv, lrd, $urandom);
      total++; if (s_alu_rdy !== m_alu_rdy) begin bad++; $display("FAIL rnd_alu_ready[%0d]: got %b want %b", c, s_alu_rdy, m_alu_rdy); end
      total++; if (s_ld_rdy !== m_ld_rdy) begin bad++; $display("FAIL rnd_ld_ready[%0d]: got %b want %b", c, s_ld_rdy, m_ld_rdy); end
      total++; if (rf_writeEnable !== m_we) begin bad++; $display("FAIL rnd_we[%0d]: got %b want %b", c, rf_writeEnable, m_we); end
      total++; if (rf_writeSelect !== m_out.rd) begin bad++; $display("FAIL rnd_sel[%0d]: got %0d want %0d", c, rf_writeSelect, m_out.rd); end
      total++; if (rf_dataIn !== m_out.data) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", c, rf_dataIn, m_out.data); end
      total++; if (pend_mask !== m_pend()) begin bad++; $display("FAIL rnd_pend[%0d]: got %h want %h", c, pend_mask, m_pend()); end
      total++; if (int'(ld_count) !== ld_q.size()) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, ld_count, ld_q.size()); end
    end
  endtask

`ifdef WB_FORWARD_EN
  task automatic test_forward();
    do_reset();
    step(1'b1, 5'd7, 32'hCAFE, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    fwdA_select = 5'd7;
    fwdB_select = 5'd0;
    #1;
    total++; if (fwdA_hit !== 1'b1 || fwdA_data !== 32'hCAFE) begin
      bad++; $display("FAIL fwdA: got %b/%h want 1/cafe", fwdA_hit, fwdA_data); end
    total++; if (fwdB_hit !== 1'b0 || fwdB_data !== '0) begin
      bad++; $display("FAIL fwdB_zero: got %b/%h want 0/0", fwdB_hit, fwdB_data); end
    fwdA_select = 5'd6;
    fwdB_select = 5'd7;
    #1;
    total++; if (fwdA_hit !== 1'b0 || fwdA_data !== '0) begin
      bad++; $display("FAIL fwdA_miss: got %b/%h want 0/0", fwdA_hit, fwdA_data); end
    total++; if (fwdB_hit !== 1'b1 || fwdB_data !== 32'hCAFE) begin
      bad++; $display("FAIL fwdB_hit: got %b/%h want 1/cafe", fwdB_hit, fwdB_data); end
    @(negedge clk);
    fwdB_select = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_fifo_full();
    test_full_ready();
    test_rd_zero();
    test_random();
`ifdef WB_FORWARD_EN
    test_forward();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
